// File: rtl/sha256_pkg.sv
// Shared constants and FSM encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_WORD_W  = 32;
  localparam logic [31:0] SHA256_PAD_MARKER = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
    ST_EMIT_DATA = 2'd1,
    ST_EMIT_PAD  = 2'd2,
    ST_EMIT_LAST = 2'd3
  } sha256_state_e;

endpackage

// File: rtl/sha256_msg_pad_if.sv
// Word-in / block-out handshake bundle between the message source, the padder and the round stages.
interface sha256_msg_pad_if;
  import sha256_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [SHA256_WORD_W-1:0]  in_data;
  logic                      in_last;
  logic [2:0]                in_bytes;
  logic                      out_valid;
  logic                      out_ready;
  logic [SHA256_BLOCK_W-1:0] out_block;
  logic                      out_first;
  logic                      out_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_block, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_block, out_first, out_last
  );

endinterface

// File: rtl/sha256_pad_word.sv
// Masks the unused bytes of a message word and appends the 0x80 marker when the word is short.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [SHA256_WORD_W-1:0] data,
  input  logic [2:0]               nbytes,
  output logic [SHA256_WORD_W-1:0] word
);

  // Byte-count driven mask-and-mark
  always_comb begin
    word = data;
    case (nbytes)
      3'd0:    word = SHA256_PAD_MARKER;
      3'd1:    word = {data[31:24], 24'h80_0000};
      3'd2:    word = {data[31:16], 16'h8000};
      3'd3:    word = {data[31:8], 8'h80};
      default: word = data;
    endcase
  end

endmodule

// File: rtl/sha256_msg_pad.sv
// SHA-256 front end: collects big-endian message words, applies FIPS 180-4 padding, emits 512-bit blocks.
module sha256_msg_pad
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sha256_msg_pad_if.slave  bus
);

  localparam logic [1:0] FILL      = ST_FILL;
  localparam logic [1:0] EMIT_DATA = ST_EMIT_DATA;
  localparam logic [1:0] EMIT_PAD  = ST_EMIT_PAD;
  localparam logic [1:0] EMIT_LAST = ST_EMIT_LAST;

  logic [1:0]  state_r, state_nxt_s;
  logic [3:0]  w_r, w_nxt_s;
  logic [63:0] len_r, len_nxt_s, len_sum_s;
  logic        first_r, first_nxt_s;
  logic        marker_r, marker_nxt_s;
  logic        in_ready_r, out_valid_r, out_last_r;
  logic [4:0]  marker_idx_s;
  logic [31:0] pad_word_s;
  logic [31:0] blk_r   [16];
  logic [31:0] blk_nxt_s [16];
  logic [SHA256_BLOCK_W-1:0] out_block_s;

  sha256_pad_word u_pad_word (
    .data   (bus.in_data),
    .nbytes (bus.in_bytes),
    .word   (pad_word_s)
  );

  // Next-state, counter and block-buffer update
  always_comb begin
    state_nxt_s  = state_r;
    w_nxt_s      = w_r;
    len_nxt_s    = len_r;
    first_nxt_s  = first_r;
    marker_nxt_s = marker_r;
    blk_nxt_s    = blk_r;
    marker_idx_s = 5'd0;
    len_sum_s    = len_r + {58'd0, bus.in_bytes, 3'd0};
    case (state_r)
      FILL: begin
        if (bus.in_valid && in_ready_r) begin
          len_nxt_s      = len_sum_s;
          blk_nxt_s[w_r] = pad_word_s;
          if (!bus.in_last) begin
            if (w_r == 4'd15) begin
              state_nxt_s = EMIT_DATA;
            end else begin
              w_nxt_s = w_r + 4'd1;
            end
          end else begin
            // A full final word pushes the marker one word on; past word 15 it moves to the next block
            if (bus.in_bytes != 3'd4) begin
              marker_idx_s = {1'b0, w_r};
              marker_nxt_s = 1'b1;
            end else begin
              marker_idx_s = {1'b0, w_r} + 5'd1;
              if (w_r != 4'd15) begin
                blk_nxt_s[w_r + 4'd1] = SHA256_PAD_MARKER;
                marker_nxt_s          = 1'b1;
              end else begin
                marker_nxt_s = 1'b0;
              end
            end
            for (int i = 0; i < 16; i++) begin
              if (5'(i) > marker_idx_s) begin
                blk_nxt_s[i] = 32'd0;
              end else begin
                blk_nxt_s[i] = blk_nxt_s[i];
              end
            end
            if (marker_idx_s <= 5'd13) begin
              blk_nxt_s[14] = len_sum_s[63:32];
              blk_nxt_s[15] = len_sum_s[31:0];
              state_nxt_s   = EMIT_LAST;
            end else begin
              state_nxt_s = EMIT_PAD;
            end
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      EMIT_DATA: begin
        if (bus.out_ready) begin
          state_nxt_s = FILL;
          w_nxt_s     = 4'd0;
          first_nxt_s = 1'b0;
        end else begin
          state_nxt_s = EMIT_DATA;
        end
      end
      EMIT_PAD: begin
        if (bus.out_ready) begin
          for (int i = 0; i < 16; i++) begin
            blk_nxt_s[i] = 32'd0;
          end
          blk_nxt_s[0]  = marker_r ? 32'd0 : SHA256_PAD_MARKER;
          blk_nxt_s[14] = len_r[63:32];
          blk_nxt_s[15] = len_r[31:0];
          state_nxt_s   = EMIT_LAST;
          first_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = EMIT_PAD;
        end
      end
      EMIT_LAST: begin
        if (bus.out_ready) begin
          state_nxt_s = FILL;
          w_nxt_s     = 4'd0;
          len_nxt_s   = 64'd0;
          first_nxt_s = 1'b1;
        end else begin
          state_nxt_s = EMIT_LAST;
        end
      end
      default: begin
        state_nxt_s = FILL;
        w_nxt_s     = 4'd0;
        len_nxt_s   = 64'd0;
      end
    endcase
  end

  // State registers; handshake outputs are registered copies of the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= FILL;
      w_r         <= 4'd0;
      len_r       <= 64'd0;
      first_r     <= 1'b1;
      marker_r    <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        blk_r[i] <= 32'd0;
      end
    end else begin
      state_r     <= state_nxt_s;
      w_r         <= w_nxt_s;
      len_r       <= len_nxt_s;
      first_r     <= first_nxt_s;
      marker_r    <= marker_nxt_s;
      in_ready_r  <= (state_nxt_s == FILL);
      out_valid_r <= (state_nxt_s != FILL);
      out_last_r  <= (state_nxt_s == EMIT_LAST);
      blk_r       <= blk_nxt_s;
    end
  end

  // Word 0 lands in the top 32 bits of the block
  always_comb begin
    out_block_s = '0;
    for (int i = 0; i < 16; i++) begin
      out_block_s[511 - 32*i -: 32] = blk_r[i];
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_block = out_block_s;
  assign bus.out_first = first_r;
  assign bus.out_last  = out_last_r;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Directed self-checking bench for sha256_msg_pad using hand-computed padded blocks.
module tb_sha256_msg_pad;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  sha256_msg_pad_if bus ();

  sha256_msg_pad dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gb(input int k);
    return 8'(k * 7 + 3);
  endfunction

  function automatic logic [31:0] ew(input int k);
    return {gb(4*k), gb(4*k+1), gb(4*k+2), gb(4*k+3)};
  endfunction

  function automatic logic [31:0] wd(input logic [511:0] b, input int k);
    return b[511 - 32*k -: 32];
  endfunction

  task automatic send_word(input logic [31:0] data, input logic [2:0] nb, input logic last, output logic ok);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_bytes = nb;
    bus.in_last  = last;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.in_ready;
    if (ok) begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input int nbytes, output logic ok);
    int nwords, rem;
    logic [31:0] d;
    logic [2:0]  nb;
    logic        wok;
    ok = 1'b1;
    nwords = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    for (int j = 0; j < nwords; j++) begin
      rem = nbytes - 4*j;
      nb  = (rem >= 4) ? 3'd4 : 3'(rem);
      for (int b = 0; b < 4; b++) begin
        d[31 - 8*b -: 8] = (4*j + b < nbytes) ? gb(4*j + b) : 8'hEE;
      end
      send_word(d, nb, (j == nwords - 1), wok);
      ok = ok & wok;
    end
  endtask

  task automatic get_block(output logic [511:0] blk, output logic f, output logic l, output logic ok);
    int n;
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok  = bus.out_valid;
    blk = bus.out_block;
    f   = bus.out_first;
    l   = bus.out_last;
    if (ok) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_bytes = 3'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_block !== 512'd0) begin n_fail++; $display("FAIL reset_out_block got %h want 0", bus.out_block); end
    n_checks++; if (bus.out_first !== 1'b1) begin n_fail++; $display("FAIL reset_out_first got %b want 1", bus.out_first); end
    n_checks++; if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_abc();
    logic ok, f, l;
    logic [511:0] b;
    send_word(32'h616263EE, 3'd3, 1'b1, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL abc_send got %b want 1", ok); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL abc_latency got %b want 1", bus.out_valid); end
    get_block(b, f, l, ok);
    n_checks++; if (b !== {32'h61626380, 448'd0, 32'h00000018}) begin n_fail++; $display("FAIL abc_block got %h want 61626380..00000018", b); end
    n_checks++; if ({ok, f, l} !== 3'b111) begin n_fail++; $display("FAIL abc_flags got ok/first/last %b want 111", {ok, f, l}); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abc_ready_after got %b want 1", bus.in_ready); end
  endtask

  task automatic test_empty();
    logic ok, f, l;
    logic [511:0] b;
    send_word(32'hDEADBEEF, 3'd0, 1'b1, ok);
    get_block(b, f, l, ok);
    n_checks++; if (b !== {32'h80000000, 480'd0}) begin n_fail++; $display("FAIL empty_block got %h want 80000000 then zeros", b); end
    n_checks++; if ({ok, f, l} !== 3'b111) begin n_fail++; $display("FAIL empty_flags got %b want 111", {ok, f, l}); end
  endtask

  task automatic test_55();
    logic ok, f, l;
    logic [511:0] b;
    int bad;
    send_msg(55, ok);
    get_block(b, f, l, ok);
    bad = 0;
    for (int k = 0; k < 13; k++) if (wd(b, k) !== ew(k)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b55_data got %0d bad words want 0", bad); end
    n_checks++; if (wd(b, 13) !== {gb(52), gb(53), gb(54), 8'h80}) begin n_fail++; $display("FAIL b55_word13 got %h want %h", wd(b, 13), {gb(52), gb(53), gb(54), 8'h80}); end
    n_checks++; if ({wd(b, 14), wd(b, 15)} !== 64'h1B8) begin n_fail++; $display("FAIL b55_len got %h want 1b8", {wd(b, 14), wd(b, 15)}); end
    n_checks++; if ({ok, f, l} !== 3'b111) begin n_fail++; $display("FAIL b55_flags got %b want 111", {ok, f, l}); end
  endtask

  task automatic test_56();
    logic ok1, f1, l1, ok2, f2, l2, ok, v;
    logic [511:0] b1, b2;
    int bad;
    send_msg(56, ok);
    get_block(b1, f1, l1, ok1);
    v = bus.out_valid;
    get_block(b2, f2, l2, ok2);
    bad = 0;
    for (int k = 0; k < 14; k++) if (wd(b1, k) !== ew(k)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b56_data got %0d bad words want 0", bad); end
    n_checks++; if ({wd(b1, 14), wd(b1, 15)} !== 64'h80000000_00000000) begin n_fail++; $display("FAIL b56_blk1_tail got %h want 8000000000000000", {wd(b1, 14), wd(b1, 15)}); end
    n_checks++; if ({ok1, f1, l1} !== 3'b110) begin n_fail++; $display("FAIL b56_blk1_flags got %b want 110", {ok1, f1, l1}); end
    n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL b56_back_to_back got %b want 1", v); end
    n_checks++; if (b2 !== {480'd0, 32'h000001C0}) begin n_fail++; $display("FAIL b56_blk2 got %h want zeros then 1c0", b2); end
    n_checks++; if ({ok2, f2, l2} !== 3'b101) begin n_fail++; $display("FAIL b56_blk2_flags got %b want 101", {ok2, f2, l2}); end
  endtask

  task automatic test_64();
    logic ok1, f1, l1, ok2, f2, l2, ok;
    logic [511:0] b1, b2;
    int bad;
    send_msg(64, ok);
    get_block(b1, f1, l1, ok1);
    get_block(b2, f2, l2, ok2);
    bad = 0;
    for (int k = 0; k < 16; k++) if (wd(b1, k) !== ew(k)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b64_data got %0d bad words want 0", bad); end
    n_checks++; if ({ok1, f1, l1} !== 3'b110) begin n_fail++; $display("FAIL b64_blk1_flags got %b want 110", {ok1, f1, l1}); end
    n_checks++; if (b2 !== {32'h80000000, 448'd0, 32'h00000200}) begin n_fail++; $display("FAIL b64_blk2 got %h want 80000000..00000200", b2); end
    n_checks++; if ({ok2, f2, l2} !== 3'b101) begin n_fail++; $display("FAIL b64_blk2_flags got %b want 101", {ok2, f2, l2}); end
  endtask

  task automatic test_backpressure();
    logic ok, f, l, stable;
    logic [511:0] cap, b;
    logic [1:0] capf;
    int n;
    send_word(32'h61626300, 3'd3, 1'b1, ok);
    n = 0;
    while (!bus.out_valid && n < 200) begin @(posedge clk); #1; n++; end
    cap  = bus.out_block;
    capf = {bus.out_first, bus.out_last};
    stable = bus.out_valid;
    bus.in_valid = 1'b1; bus.in_data = 32'h12345678; bus.in_bytes = 3'd4; bus.in_last = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      stable = stable & (bus.out_block === cap) & ({bus.out_first, bus.out_last} === capf)
                      & (bus.out_valid === 1'b1) & (bus.in_ready === 1'b0);
    end
    bus.in_valid = 1'b0;
    n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", stable); end
    get_block(b, f, l, ok);
    n_checks++; if (b !== {32'h61626380, 448'd0, 32'h00000018}) begin n_fail++; $display("FAIL bp_block got %h want 61626380..00000018", b); end
    n_checks++; if ({ok, f, l} !== 3'b111) begin n_fail++; $display("FAIL bp_flags got %b want 111", {ok, f, l}); end
  endtask

  task automatic test_reset_mid();
    logic ok, f, l, aok;
    logic [511:0] b;
    aok = 1'b1;
    for (int j = 0; j < 16; j++) begin
      send_word(32'hA5A50000 | 32'(j), 3'd4, 1'b0, ok);
      aok = aok & ok;
    end
    n_checks++; if ({aok, bus.out_valid} !== 2'b11) begin n_fail++; $display("FAIL rm_full_block got %b want 11", {aok, bus.out_valid}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid_drop got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_in_reset got %b want 0", bus.in_ready); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_word(32'h61626300, 3'd3, 1'b1, ok);
    get_block(b, f, l, ok);
    n_checks++; if (b !== {32'h61626380, 448'd0, 32'h00000018}) begin n_fail++; $display("FAIL rm_block got %h want 61626380..00000018", b); end
    n_checks++; if ({ok, f, l} !== 3'b111) begin n_fail++; $display("FAIL rm_flags got %b want 111", {ok, f, l}); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_abc();
    test_empty();
    test_55();
    test_56();
    test_64();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_msg_pad.md
# sha256_msg_pad

Front-end feeder for the SHA-256 round pipeline. It accepts a message as a stream of big-endian 32-bit words with a valid/ready handshake, applies FIPS 180-4 padding, and emits complete 512-bit blocks with first/last flags. Downstream, the round stages consume each block (word 0 in bits [511:480]) and initialise or chain the hash state. It is the producer of the `block_in` interface that the round stages consume.

## Interface
- No parameters. Widths are fixed by SHA-256.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  `in_data` / `in_last` / `in_bytes` are valid.
- `in_ready`  out  1  word accepted on `in_valid & in_ready`.
- `in_data`  in  32  message word, first byte in [31:24].
- `in_last`  in  1  final word of the message.
- `in_bytes`  in  3  number of valid bytes in this word, counted from [31:24].
  - Must be 4 when `in_last` = 0.
  - Must be 0..4 when `in_last` = 1.
  - 0 is legal only with `in_last`, and is used for empty or word-aligned tails.
- `out_valid`  out  1  `out_block` holds a complete block.
- `out_ready`  in  1  downstream accepts on `out_valid & out_ready`.
- `out_block`  out  512  padded block; word k is in bits [511-32k : 480-32k].
- `out_first`  out  1  first block of a message; downstream loads the IV.
- `out_last`  out  1  final block of a message; downstream reads the digest after it.

## Operation
- **State machine:** FILL, EMIT_DATA, EMIT_PAD, EMIT_LAST.
- **Counters:**
  - Word index `w` (4 bits).
  - Bit-length counter `len` (64 bits, wraps modulo 2^64).
  - `first_pend` flag.
  - `marker_done` flag.
- **FILL:**
  - `in_ready` = 1.
  - Each accepted word is written to word `w`, with unused bytes zeroed.
  - `len` += 8 × `in_bytes`.
  - On a non-last word:
    - If `w` < 15: `w` += 1.
    - If `w` = 15: go to EMIT_DATA.
- **Last word accepted (valid-byte count `b`):**
  - If `b` < 4: byte 0x80 is placed right after the valid bytes in word `w`. Marker word index m = `w`.
  - If `b` = 4: 0x80000000 goes into word `w`+1 (m = `w`+1). If `w` = 15, the marker is deferred to the next block (`marker_done` = 0).
  - All words after the marker are zeroed.
  - If m ≤ 13: words 14/15 = `len` (final value, high word first), then go to EMIT_LAST.
  - Otherwise: go to EMIT_PAD.
- **EMIT_DATA / EMIT_PAD / EMIT_LAST:**
  - `out_valid` = 1 and `in_ready` = 0.
  - Block and flags are held stable until the handshake.
- **On handshake:**
  - EMIT_DATA → FILL with `w` = 0.
  - EMIT_PAD → EMIT_LAST, with the buffer rebuilt as:
    - word 0 = 0x80000000 if `marker_done` = 0, else 0;
    - words 1..13 = 0;
    - words 14/15 = `len`.
  - EMIT_LAST → FILL, clearing `w` and `len` and setting `first_pend` = 1.
- **Flags:**
  - `out_first` = `first_pend`. `first_pend` clears on any output handshake and is set at reset and after an EMIT_LAST handshake.
  - `out_last` = 1 only in EMIT_LAST.
- Illegal `in_bytes` (5–7, or < 4 without `in_last`) is undefined. The bench must not drive it.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_block` = 0, `out_first` = 1, `out_last` = 0.
  - State FILL, `w` = 0, `len` = 0.
  - `in_ready` is 0 while `rst_n` is low and 1 from the first cycle after release.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Latency: `out_valid` rises the cycle after the 16th word or last word is accepted.
- Throughput:
  - Full block: 16 input cycles plus 1 emit cycle.
  - Two-block tail: 2 emit cycles minimum.
- Backpressure: `out_ready` may stay low indefinitely with no data loss. Input is stalled throughout.
- Reset asserted mid-message or mid-emit discards all state immediately.

## Structure
- Package `sha256_pkg` holds:
  - `SHA256_BLOCK_W` = 512, `SHA256_WORD_W` = 32;
  - `SHA256_PAD_MARKER` = 32'h80000000;
  - the state enum.
- Sub-module `sha256_pad_word`: combinational; takes (`in_data`, `in_bytes`) and returns the masked word with the 0x80 inserted for `b` < 4.

## Test plan
- "abc": one word 0x61626300, `in_bytes` = 3, last → one block.
  - word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018.
  - `out_first` = `out_last` = 1.
- Empty message: `in_bytes` = 0, last → one block with word 0 = 0x80000000, length 0, `first`/`last` both 1.
- 55 bytes (13 full words, then 3 bytes) → one block, word 13 ends in 0x80, word 15 = 0x000001B8.
- 56 bytes → two blocks:
  - block 1: word 14 = 0x80000000, `out_last` = 0;
  - block 2: words 0–13 = 0, word 15 = 0x000001C0, `out_first` = 0, `out_last` = 1.
- 64 bytes → two blocks: block 2 has word 0 = 0x80000000 and word 15 = 0x00000200.
- Backpressure and reset:
  - Hold `out_ready` low 5 cycles: `out_block` and flags stay stable, and `in_ready` = 0.
  - Assert `rst_n` low mid-message: `out_valid` drops immediately, and the next message gets `out_first` = 1 with the correct length.
